// File: rtl/vga_out_stage.sv
// VGA output stage: 640x480@60 raster counters, sync/blank delay alignment and RGB332 expansion.
// Optional frame-based fade when VGA_FADE_EN is defined.
module vga_out_stage #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int PIPE_DLY    = 2,
    parameter int FADE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGBIn,
    input  logic        fadeStart,
    input  logic        fadeDir,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsyncN,
    output logic        vsyncN,
    output logic        blankN,
    output logic        fadeBusy
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    function automatic logic [23:0] expand_332(input logic [7:0] px);
        logic [2:0] r, g;
        logic [1:0] b;
        {r, g, b} = px;
        return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

    function automatic logic [7:0] scale_level(input logic [7:0] ch, input logic [3:0] lvl);
        logic [11:0] prod;
        prod = {4'd0, ch} * {8'd0, lvl};
        return prod[10:3];
    endfunction

    logic [10:0] h_cnt, v_cnt;
    logic        hs_raw, vs_raw, vis_raw;
    logic        hs_pipe  [PIPE_DLY];
    logic        vs_pipe  [PIPE_DLY];
    logic        vis_pipe [PIPE_DLY];
    logic [3:0]  level;
    logic [23:0] rgb_exp;

    // Raster counters
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == 11'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == 11'(V_TOTAL - 1)) ? '0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign pixelX       = h_cnt;
    assign pixelY       = v_cnt;
    assign startOfFrame = (h_cnt == 11'(H_TOTAL - 1)) && (v_cnt == 11'(V_TOTAL - 1));

    assign hs_raw  = !((h_cnt >= 11'(H_VISIBLE + H_FRONT)) &&
                       (h_cnt <  11'(H_VISIBLE + H_FRONT + H_SYNC)));
    assign vs_raw  = !((v_cnt >= 11'(V_VISIBLE + V_FRONT)) &&
                       (v_cnt <  11'(V_VISIBLE + V_FRONT + V_SYNC)));
    assign vis_raw = (h_cnt < 11'(H_VISIBLE)) && (v_cnt < 11'(V_VISIBLE));

    // Delay line: matches the object + mux latency upstream of RGBIn
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                hs_pipe[i]  <= 1'b1;
                vs_pipe[i]  <= 1'b1;
                vis_pipe[i] <= 1'b0;
            end
        end else begin
            hs_pipe[0]  <= hs_raw;
            vs_pipe[0]  <= vs_raw;
            vis_pipe[0] <= vis_raw;
            for (int i = 1; i < PIPE_DLY; i++) begin
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                vis_pipe[i] <= vis_pipe[i-1];
            end
        end
    end

`ifdef VGA_FADE_EN
    localparam int FCW = $clog2(FADE_FRAMES + 1);

    logic           busy, dir;
    logic [FCW-1:0] frame_cnt;
    logic           at_target;

    // A fade ends once the level sits at the end matching its direction.
    assign at_target = dir ? (level == 4'd8) : (level == 4'd0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            level     <= 4'd8;
            busy      <= 1'b0;
            dir       <= 1'b0;
            frame_cnt <= '0;
        end else if (!busy) begin
            if (fadeStart && !(fadeDir ? (level == 4'd8) : (level == 4'd0))) begin
                busy      <= 1'b1;
                dir       <= fadeDir;
                frame_cnt <= '0;
            end
        end else if (at_target) begin
            busy <= 1'b0;
        end else if (startOfFrame) begin
            if (frame_cnt == FCW'(FADE_FRAMES - 1)) begin
                frame_cnt <= '0;
                level     <= dir ? level + 4'd1 : level - 4'd1;
            end else begin
                frame_cnt <= frame_cnt + FCW'(1);
            end
        end
    end

    assign fadeBusy = busy;
`else
    logic unused_fade;

    assign level       = 4'd8;
    assign fadeBusy    = 1'b0;
    assign unused_fade = fadeStart ^ fadeDir;
`endif

    assign rgb_exp = expand_332(RGBIn);

    // Output register: pixel, sync and blank leave together
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            red    <= '0;
            green  <= '0;
            blue   <= '0;
            hsyncN <= 1'b1;
            vsyncN <= 1'b1;
            blankN <= 1'b0;
        end else begin
            hsyncN <= hs_pipe[PIPE_DLY-1];
            vsyncN <= vs_pipe[PIPE_DLY-1];
            blankN <= vis_pipe[PIPE_DLY-1];
            if (vis_pipe[PIPE_DLY-1]) begin
                red   <= scale_level(rgb_exp[23:16], level);
                green <= scale_level(rgb_exp[15:8],  level);
                blue  <= scale_level(rgb_exp[7:0],   level);
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule
